vote_rank_ctrl: RTL and testbench
=================================

// Module: vote_rank_ctrl
// PURPOSE
//  Sequential controller for the vote-ranking datapath. Replaces the flat
//  7-way combinational score/token/sort with a handshaked flow: takes a token
//  base n and up to NUM_CAND 4-bit candidate codes, one per accepted beat.
//  Scores each code with one shared score_calculator instance, then picks the
//  top three by iterative max-scan and presents tokens r1..r3 on an output handshake.
// PARAMETERS
//  NUM_CAND  7  max candidate slots (2..15); slot index k = arrival order 0..NUM_CAND-1
//  DW        4  width of code, score and token
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse; honoured only in IDLE; latches n
//  n          in   4   token base for this election
//  busy       out  1   high in every state except IDLE
//  in_valid   in   1   candidate code valid
//  in_ready   out  1   high only in COLLECT
//  in_code    in   4   candidate code; bits [3:0] drive d1..d4 of score_calculator
//  in_last    in   1   qualifies the final code (ends collection early)
//  out_valid  out  1   r1..r3 and r_count valid
//  out_ready  in   1   consumer accepts result
//  r1,r2,r3   out  4   tokens of 1st/2nd/3rd ranked candidates; 0 if unfilled
//  r_count    out  2   number of valid ranks, min(entries, 3)
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE; busy, in_ready, out_valid, r1..r3,
//   r_count = 0. All slot-valid and picked flags clear. Mid-operation reset
//   drops all collected data. No output pulse is produced.
//  FSM: IDLE -start-> COLLECT -(7th accept | accept with in_last)-> SCAN
//   -(3rd pass done | passes == entries)-> OUT -(out_valid & out_ready)-> IDLE.
//  COLLECT: a beat is accepted when in_valid & in_ready. Slot k stores
//   {token=(n+k) mod 16, score=score_calculator(in_code)}; both are registered
//   on accept. The NUM_CAND-th accept ends collection even if in_last=0.
//   in_last with in_valid=0 is ignored.
//  SCAN: up to 3 passes. Each pass walks slots 0..entries-1, one slot per
//   cycle, tracking the max score among unpicked slots. Strict > compare, so a
//   tie goes to the lower slot index (earlier arrival). At pass end the winner
//   is marked picked and its token is written to r1, r2, r3 in pass order.
//   Scan latency = passes*entries cycles, plus 1 cycle to enter OUT.
//  OUT: out_valid=1. r1..r3 and r_count are held stable until accepted.
//   Unfilled ranks read 0. The cycle after acceptance: IDLE, out_valid=0.
//   r1..r3 hold their last value until the next start clears them.
//  start outside IDLE is ignored, including in the OUT acceptance cycle.
//   start in IDLE does not accept a code in the same cycle; in_ready rises next cycle.
//  Token arithmetic wraps modulo 16. Scores are unsigned 4-bit; a score of 0
//   is still a valid rankable entry.
// STRUCTURE
//  vote_rank_pkg: NUM_CAND default, state enum {IDLE,COLLECT,SCAN,OUT},
//   slot struct {token[3:0], score[3:0], valid, picked}.
//  Sub-module vote_max_scan: pass-level sequencer. Inputs are pass-start and
//   the slot vector. Outputs are the winner index and pass-done.
//   score_calculator is reused unchanged, with one instance.
// TESTING
//  1 n=2, 7 codes with scores 5,9,3,12,9,1,0 -> r1=5,r2=3,r3=6; r_count=3;
//    out_valid exactly 3*7+1 cycles after the 7th accept.
//  2 ties: all 7 scores equal, n=0 -> r1=0,r2=1,r3=2 (earliest slots win).
//  3 early end: n=A, 2 codes (scores 4,7), in_last on 2nd -> r1=B,r2=A,r3=0,
//    r_count=2. A 1-entry run gives r_count=1 and r2=r3=0.
//  4 wrap: n=F, best score in slot 1 -> r1=0. 8th in_valid after 7 accepts
//    sees in_ready=0.
//  5 backpressure: hold out_ready=0 for 10 cycles -> outputs stable, start
//    ignored. On accept, IDLE next cycle and busy=0.
//  6 rst asserted mid-COLLECT and mid-SCAN -> next cycle all outputs 0, IDLE.
//    A following full run gives correct ranks with no stale slots.

Source files
------------

// File: rtl/vote_rank_pkg.sv
// Shared types and constants for the vote-ranking controller.
//   NUM_CAND_DEF : default number of candidate slots
//   DW           : width of code, score and token
//   state_t      : controller states
//   slot_t       : one stored candidate {token, score, valid, picked}
package vote_rank_pkg;

    localparam int unsigned NUM_CAND_DEF = 7;
    localparam int unsigned DW           = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SCAN,
        OUT
    } state_t;

    typedef struct packed {
        logic [DW-1:0] token;
        logic [DW-1:0] score;
        logic          valid;
        logic          picked;
    } slot_t;

endpackage

// File: rtl/vote_rank_ctrl_if.sv
// Handshake bundle between an election driver and vote_rank_ctrl.
//   start/n                  : begin an election with token base n
//   busy                     : controller not idle
//   in_valid/in_ready        : candidate code handshake, in_code + in_last
//   out_valid/out_ready      : result handshake, r1..r3 + r_count
interface vote_rank_ctrl_if;
    import vote_rank_pkg::*;

    logic          start;
    logic [DW-1:0] n;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_code;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] r3;
    logic [1:0]    r_count;

    modport master (
        output start, n, in_valid, in_code, in_last, out_ready,
        input  busy, in_ready, out_valid, r1, r2, r3, r_count
    );

    modport slave (
        input  start, n, in_valid, in_code, in_last, out_ready,
        output busy, in_ready, out_valid, r1, r2, r3, r_count
    );

endinterface

// File: rtl/score_calculator.sv
// Combinational score of one candidate code from its four vote bits.
//   d1..d4  : vote bits, d1 carries weight 8 down to d4 weight 1
//   score_c : resulting unsigned score
module score_calculator
    import vote_rank_pkg::*;
(
    input  logic          d1,
    input  logic          d2,
    input  logic          d3,
    input  logic          d4,
    output logic [DW-1:0] score_c
);

    assign score_c = DW'({d1, d2, d3, d4});

endmodule

// File: rtl/vote_max_scan.sv
// One ranking pass: walks slots 0..entries-1, one per cycle, tracking the
// highest-scoring unpicked slot. Strict > keeps the earliest slot on ties.
//   pass_start  : (re)start a pass from slot 0 at the next edge
//   slots       : candidate slot vector
//   entries     : number of filled slots (>= 1)
//   win_idx_c   : winner index, valid while pass_done_c is high
//   pass_done_c : high during the cycle the last slot is examined
module vote_max_scan
    import vote_rank_pkg::*;
#(
    parameter  int unsigned NUM_CAND = NUM_CAND_DEF,
    localparam int unsigned IW       = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    localparam int unsigned CW       = $clog2(NUM_CAND + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pass_start,
    input  slot_t [NUM_CAND-1:0]   slots,
    input  logic [CW-1:0]          entries,
    output logic [IW-1:0]          win_idx_c,
    output logic                   pass_done_c
);

    logic          active_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] best_idx_q;
    logic [DW-1:0] best_score_q;
    logic          found_q;

    slot_t cur;
    logic  cand;
    logic  last;

    // Compare the current slot against the running best; winner includes it.
    always_comb begin
        cur         = slots[idx_q];
        cand        = cur.valid && !cur.picked &&
                      (!found_q || (cur.score > best_score_q));
        last        = (CW'(idx_q) == (entries - CW'(1)));
        pass_done_c = active_q && last;
        win_idx_c   = cand ? idx_q : best_idx_q;
    end

    // Pass walker state.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= 1'b0;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            found_q      <= 1'b0;
        end else if (pass_start) begin
            active_q     <= 1'b1;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            found_q      <= 1'b0;
        end else if (active_q) begin
            if (cand) begin
                best_idx_q   <= idx_q;
                best_score_q <= cur.score;
                found_q      <= 1'b1;
            end
            if (last) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/vote_rank_ctrl.sv
// Sequential vote-ranking controller: collects up to NUM_CAND codes, scores
// each with a shared score_calculator, ranks the top three by repeated max
// scans and presents their tokens on an output handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of vote_rank_ctrl_if (start/n, input and result handshakes)
module vote_rank_ctrl
    import vote_rank_pkg::*;
#(
    parameter int unsigned NUM_CAND = NUM_CAND_DEF
) (
    input  logic       clk,
    input  logic       rst,
    vote_rank_ctrl_if.slave bus
);

    localparam int unsigned IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int unsigned CW = $clog2(NUM_CAND + 1);

    state_t               state_q, state_d;
    slot_t [NUM_CAND-1:0] slots_q;
    logic [CW-1:0]        entries_q;
    logic [DW-1:0]        n_q;
    logic [1:0]           pass_cnt_q;
    logic                 pass_kick_q;
    logic                 busy_q, in_ready_q, out_valid_q;
    logic [DW-1:0]        r1_q, r2_q, r3_q;
    logic [1:0]           r_count_q;

    logic          accept_c;
    logic          final_pass_c;
    logic          pass_start_c;
    logic [DW-1:0] score_c;
    logic [IW-1:0] win_idx_c;
    logic          pass_done_c;

    score_calculator u_score (
        .d1      (bus.in_code[3]),
        .d2      (bus.in_code[2]),
        .d3      (bus.in_code[1]),
        .d4      (bus.in_code[0]),
        .score_c (score_c)
    );

    vote_max_scan #(.NUM_CAND(NUM_CAND)) u_scan (
        .clk         (clk),
        .rst         (rst),
        .pass_start  (pass_start_c),
        .slots       (slots_q),
        .entries     (entries_q),
        .win_idx_c   (win_idx_c),
        .pass_done_c (pass_done_c)
    );

    // Next state and pass sequencing; ranking stops at three or when slots run out.
    always_comb begin
        state_d      = state_q;
        accept_c     = in_ready_q && bus.in_valid;
        final_pass_c = (pass_cnt_q == 2'd2) ||
                       ((CW'(pass_cnt_q) + CW'(1)) == entries_q);
        pass_start_c = pass_kick_q || (pass_done_c && !final_pass_c);
        case (state_q)
            IDLE:    if (bus.start) state_d = COLLECT;
            COLLECT: if (accept_c && (bus.in_last || (entries_q == CW'(NUM_CAND - 1))))
                         state_d = SCAN;
            SCAN:    if (pass_done_c && final_pass_c) state_d = OUT;
            OUT:     if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, slot storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slots_q     <= '0;
            entries_q   <= '0;
            n_q         <= '0;
            pass_cnt_q  <= '0;
            pass_kick_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            r_count_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == COLLECT);
            out_valid_q <= (state_d == OUT);
            // First pass is launched the cycle after entering SCAN.
            pass_kick_q <= (state_q == COLLECT) && (state_d == SCAN);

            if ((state_q == IDLE) && bus.start) begin
                n_q        <= bus.n;
                entries_q  <= '0;
                pass_cnt_q <= '0;
                slots_q    <= '0;
                r1_q       <= '0;
                r2_q       <= '0;
                r3_q       <= '0;
                r_count_q  <= '0;
            end

            if (accept_c) begin
                slots_q[IW'(entries_q)] <= '{token:  DW'(n_q + DW'(entries_q)),
                                             score:  score_c,
                                             valid:  1'b1,
                                             picked: 1'b0};
                entries_q <= entries_q + CW'(1);
            end

            if (pass_done_c) begin
                slots_q[win_idx_c].picked <= 1'b1;
                case (pass_cnt_q)
                    2'd0:    r1_q <= slots_q[win_idx_c].token;
                    2'd1:    r2_q <= slots_q[win_idx_c].token;
                    default: r3_q <= slots_q[win_idx_c].token;
                endcase
                r_count_q  <= pass_cnt_q + 2'd1;
                pass_cnt_q <= pass_cnt_q + 2'd1;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign bus.r3        = r3_q;
    assign bus.r_count   = r_count_q;

endmodule

// File: tb/tb_vote_rank_ctrl.sv
// Directed bench for vote_rank_ctrl: table of elections with hand-computed
// ranks, plus backpressure and mid-operation reset sequences.
module tb_vote_rank_ctrl;
    import vote_rank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vote_rank_ctrl_if bus();

    vote_rank_ctrl #(.NUM_CAND(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // codes[4k+:4] is the code of slot k; score of a code equals its value.
    typedef struct {
        logic [3:0]  n;
        int          cnt;
        logic [27:0] codes;
        logic [3:0]  e1, e2, e3;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({bus.busy, bus.in_ready, bus.out_valid,
                         bus.r1, bus.r2, bus.r3, bus.r_count}), 32'd0);
    endtask

    task automatic run(input vec_t v, input int hold);
        int cyc;
        int passes;
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        // start with a code already valid: it must not be taken this cycle
        bus.n        = v.n;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = v.codes[3:0];
        bus.in_last  = 1'b0;
        tick;
        bus.start = 1'b0;
        bus.n     = ~v.n;
        check("start_busy_ready", 32'({bus.busy, bus.in_ready}), 32'd3);
        for (int k = 0; k < v.cnt; k++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = v.codes[4*k +: 4];
            bus.in_last  = (k == v.cnt - 1);
            cyc = 0;
            while (!bus.in_ready && cyc < 20) begin
                tick;
                cyc++;
            end
            check("in_ready_beat", 32'(bus.in_ready), 32'd1);
            tick;
            if (k == 0 && v.cnt > 1) begin
                // in_last without in_valid must not end collection
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b1;
                tick;
                bus.in_last  = 1'b0;
            end
        end
        if (v.cnt == 7) check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            tick;
            cyc++;
        end
        passes = (v.cnt < 3) ? v.cnt : 3;
        check("latency", 32'(cyc), 32'(passes * v.cnt + 1));
        check("r1", 32'(bus.r1), 32'(v.e1));
        check("r2", 32'(bus.r2), 32'(v.e2));
        check("r3", 32'(bus.r3), 32'(v.e3));
        check("r_count", 32'(bus.r_count), 32'(v.ec));
        for (int h = 0; h < hold; h++) begin
            bus.start = 1'b1;
            bus.n     = 4'h9;
            tick;
            check("hold_stable", 32'({bus.out_valid, bus.busy, bus.r1, bus.r2, bus.r3, bus.r_count}),
                  32'({2'b11, v.e1, v.e2, v.e3, v.ec}));
        end
        bus.out_ready = 1'b1;
        bus.start     = (hold > 0);
        tick;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("accept_idle", 32'({bus.out_valid, bus.busy}), 32'd0);
        tick;
        check("stay_idle_ranks", 32'({bus.busy, bus.r1, bus.r2, bus.r3}),
              32'({1'b0, v.e1, v.e2, v.e3}));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.n         = '0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        //          n     cnt codes         e1    e2    e3    ec
        vecs[0] = '{4'h2, 7, 28'h019C395, 4'h5, 4'h3, 4'h6, 2'd3};
        vecs[1] = '{4'h0, 7, 28'h6666666, 4'h0, 4'h1, 4'h2, 2'd3};
        vecs[2] = '{4'hA, 2, 28'h0000074, 4'hB, 4'hA, 4'h0, 2'd2};
        vecs[3] = '{4'h3, 1, 28'h0000000, 4'h3, 4'h0, 4'h0, 2'd1};
        vecs[4] = '{4'hF, 7, 28'h75013E2, 4'h0, 4'h5, 4'h4, 2'd3};
        vecs[5] = '{4'h8, 3, 28'h0000F11, 4'hA, 4'h8, 4'h9, 2'd3};
        vecs[6] = '{4'hC, 4, 28'h0003000, 4'hF, 4'hC, 4'hD, 2'd3};

        repeat (3) tick;
        check_zero("reset_state");
        rst = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) run(vecs[i], 0);

        // result held under backpressure, start ignored outside IDLE
        run(vecs[0], 10);

        // reset in the middle of collection
        bus.n        = 4'h4;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = 4'hF;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_zero("rst_mid_collect");
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick;
        check_zero("after_rst_collect");

        // reset in the middle of scanning
        bus.n        = 4'h1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = 4'hE;
        tick;
        bus.start = 1'b0;
        repeat (7) tick;
        bus.in_valid = 1'b0;
        repeat (5) tick;
        check("in_scan_busy", 32'({bus.busy, bus.in_ready, bus.out_valid}), 32'd4);
        rst = 1'b1;
        tick;
        check_zero("rst_mid_scan");
        rst = 1'b0;
        tick;

        // full runs after reset: no stale slots
        run(vecs[0], 0);
        run(vecs[4], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
